// File: rtl/snn_pkg.sv
// Shared field layout and constants for the SNN spike-flatten stage.
// The input word is {valid, channel, y, x}, one byte each.
package snn_pkg;

    localparam logic [7:0]  SPIKE_VALID_BYTE = 8'h01;
    localparam int          X_LSB            = 0;
    localparam int          Y_LSB            = 8;
    localparam int          CH_LSB           = 16;
    localparam int          VALID_LSB        = 24;
    localparam logic [31:0] MARKER_WORD      = 32'h0000_0000;
    localparam int          IDX_FULL_W       = 24;

    typedef enum logic [1:0] {
        CLS_EMPTY = 2'd0,
        CLS_DROP  = 2'd1,
        CLS_SPIKE = 2'd2
    } beat_class_e;

endpackage

// File: rtl/snn_sync_fifo.sv
// Show-ahead synchronous FIFO: dout always presents the head entry.
// Only pointers and occupancy are reset; storage is left untouched.
module snn_sync_fifo #(
    parameter int WIDTH = 33,
    parameter int DEPTH = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push,
    input  logic [WIDTH-1:0]       din,
    input  logic                   pop,
    output logic [WIDTH-1:0]       dout,
    output logic [$clog2(DEPTH):0] level,
    output logic                   full,
    output logic                   empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_pop;

    assign empty  = (level == '0);
    assign full   = (level == (AW+1)'(DEPTH));
    assign do_pop = pop && !empty;
    assign dout   = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)
                rd_ptr <= rd_ptr + 1'b1;
            case ({push, do_pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/snn_spike_flatten.sv
// Maps {channel, y, x} spike events to flat neuron indices and buffers them
// for the fully-connected layer, keeping end-of-timestep markers intact.
module snn_spike_flatten
    import snn_pkg::*;
#(
    parameter int IN_WIDTH    = 14,
    parameter int IN_HEIGHT   = 14,
    parameter int IN_CHANNELS = 32,
    parameter int FIFO_DEPTH  = 16,
    parameter int INDEX_WIDTH = 16
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          enable,
    input  logic [31:0]                   s_axis_input_tdata,
    input  logic                          s_axis_input_tvalid,
    output logic                          s_axis_input_tready,
    input  logic                          s_axis_input_tlast,
    output logic [31:0]                   m_axis_output_tdata,
    output logic                          m_axis_output_tvalid,
    input  logic                          m_axis_output_tready,
    output logic                          m_axis_output_tlast,
    output logic [31:0]                   input_spike_count,
    output logic [31:0]                   output_spike_count,
    output logic [31:0]                   drop_count,
    output logic [15:0]                   timestep_count,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          busy
);
    localparam int                    LVL_W   = $clog2(FIFO_DEPTH) + 1;
    localparam logic [IDX_FULL_W-1:0] PLANE   = IDX_FULL_W'(IN_HEIGHT * IN_WIDTH);
    localparam logic [IDX_FULL_W-1:0] ROW     = IDX_FULL_W'(IN_WIDTH);
    localparam logic [IDX_FULL_W-1:0] IDX_MSK = IDX_FULL_W'((64'd1 << INDEX_WIDTH) - 64'd1);

    logic [7:0]            in_vbyte, in_ch, in_y, in_x;
    logic [IDX_FULL_W-1:0] idx_p0;
    beat_class_e           cls_p0;
    logic                  accept, load_p0;
    logic [31:0]           word_p0;
    logic                  vld_p1, last_p1;
    logic [31:0]           data_p1;
    logic [32:0]           fifo_head, out_hold_p2;
    logic                  fifo_full, fifo_empty, pop;
    logic [LVL_W+1:0]      occ_nxt;

    assign in_vbyte = s_axis_input_tdata[VALID_LSB +: 8];
    assign in_ch    = s_axis_input_tdata[CH_LSB +: 8];
    assign in_y     = s_axis_input_tdata[Y_LSB +: 8];
    assign in_x     = s_axis_input_tdata[X_LSB +: 8];

    // Stage 0: classify the incoming beat and compute its flat index
    assign idx_p0 = IDX_FULL_W'(in_ch) * PLANE + IDX_FULL_W'(in_y) * ROW + IDX_FULL_W'(in_x);

    always_comb begin
        cls_p0 = CLS_SPIKE;
        if (in_vbyte == 8'h00)
            cls_p0 = CLS_EMPTY;
        else if (int'(in_x) >= IN_WIDTH || int'(in_y) >= IN_HEIGHT || int'(in_ch) >= IN_CHANNELS)
            cls_p0 = CLS_DROP;
    end

    assign accept  = s_axis_input_tvalid && s_axis_input_tready;
    assign load_p0 = accept && (cls_p0 == CLS_SPIKE || s_axis_input_tlast);
    assign word_p0 = (cls_p0 == CLS_SPIKE) ? {SPIKE_VALID_BYTE, idx_p0 & IDX_MSK} : MARKER_WORD;

    // Stage 1: single holding register ahead of the FIFO
    always_ff @(posedge clk) begin
        if (load_p0) begin
            data_p1 <= word_p0;
            last_p1 <= s_axis_input_tlast;
        end
    end

    // Stage 2: show-ahead FIFO, written unconditionally whenever stage 1 is valid
    snn_sync_fifo #(
        .WIDTH (33),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (vld_p1),
        .din   ({last_p1, data_p1}),
        .pop   (pop),
        .dout  (fifo_head),
        .level (fifo_level),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign pop                  = !fifo_empty && m_axis_output_tready;
    assign m_axis_output_tvalid = !fifo_empty;
    assign {m_axis_output_tlast, m_axis_output_tdata} = fifo_empty ? out_hold_p2 : fifo_head;
    assign busy                 = vld_p1 || !fifo_empty;

    // Ready looks at next-cycle occupancy so a beat accepted now always has a slot
    assign occ_nxt = (LVL_W+2)'(fifo_level) + (LVL_W+2)'(vld_p1)
                   + (LVL_W+2)'(load_p0) - (LVL_W+2)'(pop);

    always_ff @(posedge clk) begin
        if (!reset) begin
            vld_p1              <= 1'b0;
            s_axis_input_tready <= 1'b0;
            out_hold_p2         <= '0;
            input_spike_count   <= '0;
            output_spike_count  <= '0;
            drop_count          <= '0;
            timestep_count      <= '0;
        end else begin
            vld_p1              <= load_p0;
            s_axis_input_tready <= enable && (occ_nxt < (LVL_W+2)'(FIFO_DEPTH));
            if (!fifo_empty)
                out_hold_p2 <= fifo_head;
            if (accept && cls_p0 == CLS_SPIKE)
                input_spike_count <= input_spike_count + 1'b1;
            if (accept && cls_p0 == CLS_DROP)
                drop_count <= drop_count + 1'b1;
            if (pop && fifo_head[31:24] == SPIKE_VALID_BYTE)
                output_spike_count <= output_spike_count + 1'b1;
            if (pop && fifo_head[32])
                timestep_count <= timestep_count + 1'b1;
            assert (!(vld_p1 && fifo_full && !pop));
        end
    end

endmodule

// File: tb/tb_snn_spike_flatten.sv
// Randomized bench for snn_spike_flatten against a queue-based reference model,
// plus directed latency, drop, backpressure, reset and enable scenarios.
module tb_snn_spike_flatten;

    localparam int W = 14, H = 14, C = 32, D = 16, IW = 16;

    logic        clk = 1'b0;
    logic        rst_n, enable;
    logic [31:0] in_tdata;
    logic        in_tvalid, in_tready, in_tlast;
    logic [31:0] out_tdata;
    logic        out_tvalid, out_tready, out_tlast;
    logic [31:0] in_cnt, out_cnt, drp_cnt;
    logic [15:0] ts_cnt;
    logic [4:0]  level;
    logic        busy;

    always #5 clk = ~clk;

    snn_spike_flatten #(
        .IN_WIDTH(W), .IN_HEIGHT(H), .IN_CHANNELS(C), .FIFO_DEPTH(D), .INDEX_WIDTH(IW)
    ) dut (
        .clk(clk), .reset(rst_n), .enable(enable),
        .s_axis_input_tdata(in_tdata), .s_axis_input_tvalid(in_tvalid),
        .s_axis_input_tready(in_tready), .s_axis_input_tlast(in_tlast),
        .m_axis_output_tdata(out_tdata), .m_axis_output_tvalid(out_tvalid),
        .m_axis_output_tready(out_tready), .m_axis_output_tlast(out_tlast),
        .input_spike_count(in_cnt), .output_spike_count(out_cnt),
        .drop_count(drp_cnt), .timestep_count(ts_cnt),
        .fifo_level(level), .busy(busy)
    );

    int          n_vec = 0;
    int          n_err = 0;
    logic [32:0] exp_q[$];
    logic [31:0] m_in, m_out, m_drop;
    logic [15:0] m_ts;

    task automatic check(input string tag, input logic [32:0] got, input logic [32:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Reference: the accepted beat's effect on the expected output stream
    task automatic model_accept(input logic [31:0] d, input logic l);
        int v  = int'(d[31:24]);
        int ch = int'(d[23:16]);
        int y  = int'(d[15:8]);
        int x  = int'(d[7:0]);
        bit spike = 1'b0;
        if (v != 0) begin
            if (x >= W || y >= H || ch >= C) m_drop++;
            else begin spike = 1'b1; m_in++; end
        end
        if (spike) exp_q.push_back({l, 8'h01, 24'(ch * H * W + y * W + x)});
        else if (l) exp_q.push_back({1'b1, 32'h0});
    endtask

    // Called at a negedge with inputs set; advances one clock and checks counters
    task automatic cycle(output bit acc, output bit pop);
        logic [32:0] e;
        acc = rst_n && in_tvalid && in_tready;
        pop = rst_n && out_tvalid && out_tready;
        if (!rst_n) begin
            exp_q.delete();
            m_in = 0; m_out = 0; m_drop = 0; m_ts = 0;
        end
        if (pop) begin
            check("pop_expected", 33'(exp_q.size() != 0), 33'd1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("out_beat", {out_tlast, out_tdata}, e);
                if (e[31:24] == 8'h01) m_out++;
                if (e[32]) m_ts++;
            end
        end
        if (acc) model_accept(in_tdata, in_tlast);
        @(posedge clk);
        @(negedge clk);
        check("in_cnt", 33'(in_cnt), 33'(m_in));
        check("out_cnt", 33'(out_cnt), 33'(m_out));
        check("drop_cnt", 33'(drp_cnt), 33'(m_drop));
        check("ts_cnt", 33'(ts_cnt), 33'(m_ts));
        check("level_max", 33'(level <= 5'(D)), 33'd1);
    endtask

    task automatic drain();
        bit a, p;
        int n = 0;
        in_tvalid  = 1'b0;
        out_tready = 1'b1;
        while ((out_tvalid || busy) && n < 200) begin
            cycle(a, p);
            n++;
        end
        check("drain_timeout", 33'(n < 200), 33'd1);
        check("model_empty", 33'(exp_q.size()), 33'd0);
    endtask

    function automatic logic [31:0] mk(input int ch, input int y, input int x);
        return {8'h01, 8'(ch), 8'(y), 8'(x)};
    endfunction

    function automatic logic [31:0] rand_beat();
        int mode = int'($urandom_range(0, 9));
        logic [31:0] d = $urandom;
        if (mode < 2) d[31:24] = 8'h00;
        else begin
            d[31:24] = 8'($urandom_range(1, 255));
            d[23:16] = 8'($urandom_range(0, C - 1));
            d[15:8]  = 8'($urandom_range(0, H - 1));
            d[7:0]   = 8'($urandom_range(0, W - 1));
            if (mode < 4) begin
                case ($urandom_range(0, 2))
                    0:       d[7:0]   = 8'($urandom_range(W, 255));
                    1:       d[15:8]  = 8'($urandom_range(H, 255));
                    default: d[23:16] = 8'($urandom_range(C, 255));
                endcase
            end
        end
        return d;
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        bit a, p;
        int acc_n, pop_n, n;
        rst_n = 1'b0; enable = 1'b0; in_tdata = '0; in_tvalid = 1'b0; in_tlast = 1'b0;
        out_tready = 1'b0;
        m_in = 0; m_out = 0; m_drop = 0; m_ts = 0;
        @(negedge clk);
        cycle(a, p);
        cycle(a, p);
        check("rst_tready", 33'(in_tready), 33'd0);
        check("rst_tvalid", 33'(out_tvalid), 33'd0);
        check("rst_tdata", {out_tlast, out_tdata}, 33'd0);
        check("rst_level", 33'(level), 33'd0);
        check("rst_busy", 33'(busy), 33'd0);
        rst_n = 1'b1; enable = 1'b1; out_tready = 1'b1;
        cycle(a, p);
        check("tready_up", 33'(in_tready), 33'd1);

        // Index mapping and latency
        in_tdata = mk(2, 3, 5); in_tvalid = 1'b1;
        cycle(a, p);
        check("lat_accept", 33'(a), 33'd1);
        in_tvalid = 1'b0;
        check("lat_c1_tvalid", 33'(out_tvalid), 33'd0);
        cycle(a, p);
        check("lat_c2_tvalid", 33'(out_tvalid), 33'd1);
        check("lat_c2_tdata", 33'(out_tdata), 33'h0_010001B7);
        cycle(a, p);
        check("lat_in_cnt", 33'(in_cnt), 33'd1);
        check("lat_out_cnt", 33'(out_cnt), 33'd1);

        // Dropped beat carrying tlast becomes a marker
        in_tdata = mk(0, 0, 14); in_tlast = 1'b1; in_tvalid = 1'b1;
        cycle(a, p);
        in_tvalid = 1'b0; in_tlast = 1'b0;
        cycle(a, p);
        check("mark_tvalid", 33'(out_tvalid), 33'd1);
        check("mark_beat", {out_tlast, out_tdata}, {1'b1, 32'h0});
        cycle(a, p);
        check("mark_drop_cnt", 33'(drp_cnt), 33'd1);
        check("mark_ts_cnt", 33'(ts_cnt), 33'd1);

        // Empty beat without tlast produces nothing
        in_tdata = {8'h00, 8'd1, 8'd1, 8'd1}; in_tvalid = 1'b1;
        cycle(a, p);
        in_tvalid = 1'b0;
        repeat (3) cycle(a, p);
        check("empty_tvalid", 33'(out_tvalid), 33'd0);
        check("empty_busy", 33'(busy), 33'd0);

        // Backpressure: 40 spikes against a stalled consumer
        out_tready = 1'b0; acc_n = 0;
        in_tdata = mk(0, 0, 0); in_tvalid = 1'b1;
        for (int c = 0; c < 60; c++) begin
            cycle(a, p);
            if (a) begin
                acc_n++;
                in_tdata = mk(acc_n % C, acc_n % H, (acc_n * 3) % W);
            end
        end
        check("bp_accepted", 33'(acc_n), 33'd16);
        check("bp_tready", 33'(in_tready), 33'd0);
        check("bp_level", 33'(level), 33'd16);
        out_tready = 1'b1; n = 0;
        while (acc_n < 40 && n < 400) begin
            cycle(a, p);
            if (a) begin
                acc_n++;
                in_tdata = mk(acc_n % C, acc_n % H, (acc_n * 3) % W);
                if (acc_n == 40) in_tvalid = 1'b0;
            end
            n++;
        end
        check("bp_all_accepted", 33'(acc_n), 33'd40);
        drain();

        // Reset mid-stream with 5 entries buffered
        out_tready = 1'b0; acc_n = 0; n = 0;
        in_tdata = mk(1, 1, 1); in_tvalid = 1'b1;
        while (acc_n < 5 && n < 50) begin
            cycle(a, p);
            if (a) begin acc_n++; in_tdata = mk(1, 1, acc_n + 1); end
            n++;
        end
        in_tvalid = 1'b0;
        cycle(a, p);
        check("rs_level_before", 33'(level), 33'd5);
        rst_n = 1'b0;
        cycle(a, p);
        rst_n = 1'b1;
        check("rs_tvalid", 33'(out_tvalid), 33'd0);
        check("rs_level", 33'(level), 33'd0);
        check("rs_busy", 33'(busy), 33'd0);
        out_tready = 1'b1;
        cycle(a, p);
        in_tdata = mk(31, 13, 13); in_tvalid = 1'b1;
        cycle(a, p);
        check("rs_fresh_accept", 33'(a), 33'd1);
        drain();

        // Enable gating: buffered beats drain while input stays closed
        out_tready = 1'b0; acc_n = 0; n = 0;
        in_tdata = mk(4, 5, 6); in_tvalid = 1'b1;
        while (acc_n < 3 && n < 50) begin
            cycle(a, p);
            if (a) begin acc_n++; in_tdata = mk(4, 5, 6 + acc_n); end
            n++;
        end
        in_tvalid = 1'b0;
        cycle(a, p);
        enable = 1'b0;
        cycle(a, p);
        check("en_tready", 33'(in_tready), 33'd0);
        check("en_level", 33'(level), 33'd3);
        out_tready = 1'b1; pop_n = 0;
        for (int c = 0; c < 8; c++) begin
            cycle(a, p);
            if (p) pop_n++;
        end
        check("en_drained", 33'(pop_n), 33'd3);
        check("en_tready_held", 33'(in_tready), 33'd0);
        check("en_busy", 33'(busy), 33'd0);
        enable = 1'b1;

        // Randomized traffic
        in_tdata = rand_beat(); in_tlast = ($urandom_range(0, 3) == 0); in_tvalid = 1'b1;
        for (int c = 0; c < 1500; c++) begin
            enable     = ($urandom_range(0, 9) != 0);
            out_tready = ($urandom_range(0, 3) != 0);
            cycle(a, p);
            if (a || !in_tvalid) begin
                in_tdata  = rand_beat();
                in_tlast  = ($urandom_range(0, 3) == 0);
                in_tvalid = ($urandom_range(0, 4) != 0);
            end
        end
        enable = 1'b1;
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
